des_decrypt_core: RTL and testbench



---
 rtl/des_pkg.sv | 68 ++++++
 rtl/des_feistel_f.sv | 33 +++
 rtl/des_sboxes.sv | 32 +++
 rtl/des_decrypt_core.sv | 139 +++++++++++++
 tb/tb_des_decrypt_core.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES permutation tables, S-box contents, key-schedule constants and FSM state type.
package des_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int BLOCK_W    = 64;
  localparam int HALF_W     = 32;
  localparam int KEY_HALF_W = 28;
  localparam int SUBKEY_W   = 48;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  // Right-rotate amounts for decryption: the encryption left-shift schedule played backwards.
  localparam logic [1:0] RSHIFT [0:15] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [5:0] IP_T [0:63] = '{
    57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7,
    56, 48, 40, 32, 24, 16,  8,  0,  58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,  62, 54, 46, 38, 30, 22, 14,  6};

  localparam logic [5:0] FP_T [0:63] = '{
    39,  7, 47, 15, 55, 23, 63, 31,  38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,  36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,  34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25,  32,  0, 40,  8, 48, 16, 56, 24};

  localparam logic [4:0] E_T [0:47] = '{
    31,  0,  1,  2,  3,  4,   3,  4,  5,  6,  7,  8,
     7,  8,  9, 10, 11, 12,  11, 12, 13, 14, 15, 16,
    15, 16, 17, 18, 19, 20,  19, 20, 21, 22, 23, 24,
    23, 24, 25, 26, 27, 28,  27, 28, 29, 30, 31,  0};

  localparam logic [4:0] P_T [0:31] = '{
    15,  6, 19, 20, 28, 11, 27, 16,   0, 14, 22, 25,  4, 17, 30,  9,
     1,  7, 23, 13, 31, 26,  2,  8,  18, 12, 29,  5, 21, 10,  3, 24};

  localparam logic [5:0] PC1_T [0:55] = '{
    56, 48, 40, 32, 24, 16,  8,   0, 57, 49, 41, 33, 25, 17,
     9,  1, 58, 50, 42, 34, 26,  18, 10,  2, 59, 51, 43, 35,
    62, 54, 46, 38, 30, 22, 14,   6, 61, 53, 45, 37, 29, 21,
    13,  5, 60, 52, 44, 36, 28,  20, 12,  4, 27, 19, 11,  3};

  localparam logic [5:0] PC2_T [0:47] = '{
    13, 16, 10, 23,  0,  4,   2, 27, 14,  5, 20,  9,
    22, 18, 11,  3, 25,  7,  15,  6, 26, 19, 12,  1,
    40, 51, 30, 36, 46, 54,  29, 39, 50, 44, 32, 47,
    43, 48, 38, 55, 33, 52,  45, 41, 49, 35, 28, 31};

  // Indexed by {row, column} = {b0, b5, b1..b4} of the 6-bit group.
  localparam logic [3:0] SBOX [0:7][0:63] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

endpackage

// File: rtl/des_feistel_f.sv
// rtl/des_feistel_f.sv - combinational DES round function f(R, K): expand, key mix, substitute, permute.
module des_feistel_f
  import des_pkg::*;
(
  input  logic [0:HALF_W-1]   r,
  input  logic [0:SUBKEY_W-1] subkey,
  output logic [0:HALF_W-1]   result
);

  logic [0:SUBKEY_W-1] expanded;
  logic [0:SUBKEY_W-1] mixed;
  logic [0:HALF_W-1]   sout;

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_expand
    assign expanded[i] = r[E_T[i]];
  end

  assign mixed = expanded ^ subkey;

  S1Box u_s1 (.addr(mixed[0:5]),   .data(sout[0:3]));
  S2Box u_s2 (.addr(mixed[6:11]),  .data(sout[4:7]));
  S3Box u_s3 (.addr(mixed[12:17]), .data(sout[8:11]));
  S4Box u_s4 (.addr(mixed[18:23]), .data(sout[12:15]));
  S5Box u_s5 (.addr(mixed[24:29]), .data(sout[16:19]));
  S6Box u_s6 (.addr(mixed[30:35]), .data(sout[20:23]));
  S7Box u_s7 (.addr(mixed[36:41]), .data(sout[24:27]));
  S8Box u_s8 (.addr(mixed[42:47]), .data(sout[28:31]));

  for (genvar i = 0; i < HALF_W; i++) begin : g_perm
    assign result[i] = sout[P_T[i]];
  end

endmodule

// File: rtl/des_sboxes.sv
// rtl/des_sboxes.sv - combinational DES substitution boxes S1..S8 (6-bit in, 4-bit out).
module S1Box import des_pkg::*; (input logic [0:5] addr, output logic [0:3] data);
  assign data = SBOX[0][{addr[0], addr[5], addr[1:4]}];
endmodule

module S2Box import des_pkg::*; (input logic [0:5] addr, output logic [0:3] data);
  assign data = SBOX[1][{addr[0], addr[5], addr[1:4]}];
endmodule

module S3Box import des_pkg::*; (input logic [0:5] addr, output logic [0:3] data);
  assign data = SBOX[2][{addr[0], addr[5], addr[1:4]}];
endmodule

module S4Box import des_pkg::*; (input logic [0:5] addr, output logic [0:3] data);
  assign data = SBOX[3][{addr[0], addr[5], addr[1:4]}];
endmodule

module S5Box import des_pkg::*; (input logic [0:5] addr, output logic [0:3] data);
  assign data = SBOX[4][{addr[0], addr[5], addr[1:4]}];
endmodule

module S6Box import des_pkg::*; (input logic [0:5] addr, output logic [0:3] data);
  assign data = SBOX[5][{addr[0], addr[5], addr[1:4]}];
endmodule

module S7Box import des_pkg::*; (input logic [0:5] addr, output logic [0:3] data);
  assign data = SBOX[6][{addr[0], addr[5], addr[1:4]}];
endmodule

module S8Box import des_pkg::*; (input logic [0:5] addr, output logic [0:3] data);
  assign data = SBOX[7][{addr[0], addr[5], addr[1:4]}];
endmodule

// File: rtl/des_decrypt_core.sv
// rtl/des_decrypt_core.sv - iterative DES decryption, one Feistel round per clock, subkeys generated K16 first.
module des_decrypt_core
  import des_pkg::*;
#(
  parameter int PARITY_CHECK = 0
) (
  input  logic              wClk,
  input  logic              wReset,
  input  logic              wStart,
  input  logic [0:BLOCK_W-1] wKey,
  input  logic [0:BLOCK_W-1] wCipherText,
  output logic              wReady,
  output logic              wDone,
  output logic [0:BLOCK_W-1] wPlainText,
  output logic              wParityErr
);

  state_t state, state_next;
  logic [3:0] rnd;
  logic [0:HALF_W-1] l_q, r_q;
  logic [0:KEY_HALF_W-1] c_q, d_q;
  logic [0:KEY_HALF_W-1] c_rot, d_rot;
  logic [0:2*KEY_HALF_W-1] cd_rot;
  logic [0:2*KEY_HALF_W-1] pc1_key;
  logic [0:BLOCK_W-1] ip_ct;
  logic [0:BLOCK_W-1] rl;
  logic [0:BLOCK_W-1] fp_out;
  logic [0:SUBKEY_W-1] subkey;
  logic [0:HALF_W-1] f_out;
  logic [7:0] byte_even;
  logic accept, round_en, finish;

  always_ff @(posedge wClk) begin
    if (wReset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ROUND;
      ROUND:   if (rnd == 4'(NUM_ROUNDS - 1)) state_next = FINAL;
      FINAL:   state_next = accept ? ROUND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wReady   = 1'b0;
    round_en = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:  wReady = 1'b1;
      ROUND: round_en = 1'b1;
      FINAL: begin
        wReady = 1'b1;
        finish = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = wStart & wReady;

  // Static wiring of the fixed permutations.
  for (genvar i = 0; i < BLOCK_W; i++) begin : g_ip_fp
    assign ip_ct[i]  = wCipherText[IP_T[i]];
    assign fp_out[i] = rl[FP_T[i]];
  end

  for (genvar i = 0; i < 2 * KEY_HALF_W; i++) begin : g_pc1
    assign pc1_key[i] = wKey[PC1_T[i]];
  end

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
    assign subkey[i] = cd_rot[PC2_T[i]];
  end

  for (genvar b = 0; b < 8; b++) begin : g_parity
    assign byte_even[b] = ~^wKey[8*b +: 8];
  end

  assign rl     = {r_q, l_q};
  assign cd_rot = {c_rot, d_rot};

  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    case (RSHIFT[rnd])
      2'd1: begin
        c_rot = {c_q[27], c_q[0:26]};
        d_rot = {d_q[27], d_q[0:26]};
      end
      2'd2: begin
        c_rot = {c_q[26:27], c_q[0:25]};
        d_rot = {d_q[26:27], d_q[0:25]};
      end
      default: ;
    endcase
  end

  des_feistel_f u_f (
    .r      (r_q),
    .subkey (subkey),
    .result (f_out)
  );

  // A back-to-back accept in FINAL reloads L/R while the old L/R still feed FP.
  always_ff @(posedge wClk) begin
    if (wReset) begin
      wDone      <= 1'b0;
      wPlainText <= '0;
      wParityErr <= 1'b0;
      rnd        <= '0;
      l_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
    end else begin
      wDone <= finish;
      if (finish) wPlainText <= fp_out;
      if (accept) begin
        l_q        <= ip_ct[0:HALF_W-1];
        r_q        <= ip_ct[HALF_W:BLOCK_W-1];
        c_q        <= pc1_key[0:KEY_HALF_W-1];
        d_q        <= pc1_key[KEY_HALF_W:2*KEY_HALF_W-1];
        rnd        <= '0;
        wParityErr <= (PARITY_CHECK != 0) && (|byte_even);
      end else if (round_en) begin
        l_q <= r_q;
        r_q <= l_q ^ f_out;
        c_q <= c_rot;
        d_q <= d_rot;
        rnd <= rnd + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_des_decrypt_core.sv
// tb/tb_des_decrypt_core.sv - directed-vector bench for des_decrypt_core.
module tb_des_decrypt_core;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] K3 = 64'h0000000000000000;
  localparam logic [63:0] C3 = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] P3 = 64'h0000000000000000;

  logic wClk = 1'b0;
  logic wReset, wStart;
  logic [0:63] wKey, wCipherText;
  logic wReady, wDone, wParityErr;
  logic [0:63] wPlainText;
  logic np_ready, np_done, np_parity_err;
  logic [0:63] np_plain_text;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 wClk = ~wClk;

  des_decrypt_core #(.PARITY_CHECK(1)) u_dut (
    .wClk(wClk), .wReset(wReset), .wStart(wStart), .wKey(wKey), .wCipherText(wCipherText),
    .wReady(wReady), .wDone(wDone), .wPlainText(wPlainText), .wParityErr(wParityErr)
  );

  des_decrypt_core #(.PARITY_CHECK(0)) u_dut_np (
    .wClk(wClk), .wReset(wReset), .wStart(wStart), .wKey(wKey), .wCipherText(wCipherText),
    .wReady(np_ready), .wDone(np_done), .wPlainText(np_plain_text), .wParityErr(np_parity_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge wClk);
    #1;
  endtask

  task automatic do_reset;
    wReset = 1'b1;
    tick;
    tick;
    wReset = 1'b0;
  endtask

  task automatic start(input logic [63:0] key, input logic [63:0] ct, input bit hold);
    wKey        = key;
    wCipherText = ct;
    wStart      = 1'b1;
    tick;
    if (!hold) wStart = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic rdy16);
    lat   = -1;
    rdy16 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (n == 16) rdy16 = wReady;
      if (wDone) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      tick;
      if (wDone) cnt++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    logic r16;
    wReset = 1'b0;
    wStart = 1'b0;
    wKey = '0;
    wCipherText = '0;

    do_reset;
    check_eq("rst_ready", 64'(wReady), 64'd1);
    check_eq("rst_done", 64'(wDone), 64'd0);
    check_eq("rst_pt", wPlainText, 64'd0);
    check_eq("rst_perr", 64'(wParityErr), 64'd0);

    // Classic vector, single pulse.
    start(K1, C1, 1'b0);
    check_eq("t1_busy", 64'(wReady), 64'd0);
    check_eq("t1_perr", 64'(wParityErr), 64'd0);
    wait_done(lat, r16);
    check_eq("t1_latency", 64'(lat), 64'd17);
    check_eq("t1_ready_final", 64'(r16), 64'd1);
    check_eq("t1_pt", wPlainText, P1);
    check_eq("t1_np_pt", np_plain_text, P1);
    tick;
    check_eq("t1_done_pulse", 64'(wDone), 64'd0);
    check_eq("t1_hold", wPlainText, P1);
    check_eq("t1_idle", 64'(wReady), 64'd1);

    // wStart held high: back-to-back accept on the FINAL cycle.
    start(K2, C2, 1'b1);
    wait_done(lat, r16);
    check_eq("t2_latency", 64'(lat), 64'd17);
    check_eq("t2_pt", wPlainText, P2);
    check_eq("t2_reaccept", 64'(wReady), 64'd0);
    wait_done(lat, r16);
    check_eq("t2_latency2", 64'(lat), 64'd17);
    check_eq("t2_pt2", wPlainText, P2);
    wStart = 1'b0;
    wait_done(lat, r16);
    check_eq("t2_latency3", 64'(lat), 64'd17);
    check_eq("t2_pt3", wPlainText, P2);

    // All-zero key: every byte has even parity.
    start(K3, C3, 1'b0);
    check_eq("t3_perr", 64'(wParityErr), 64'd1);
    check_eq("t3_np_perr", 64'(np_parity_err), 64'd0);
    wait_done(lat, r16);
    check_eq("t3_latency", 64'(lat), 64'd17);
    check_eq("t3_pt", wPlainText, P3);
    check_eq("t3_perr_hold", 64'(wParityErr), 64'd1);

    // Requests while busy are dropped.
    start(K1, C1, 1'b0);
    cnt = 0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5 || n == 10) begin
        wKey        = K3;
        wCipherText = C3;
        wStart      = 1'b1;
      end else begin
        wStart = 1'b0;
      end
      tick;
      if (wDone) begin
        cnt++;
        if (lat < 0) lat = n;
      end
    end
    check_eq("t4_done_cnt", 64'(cnt), 64'd1);
    check_eq("t4_latency", 64'(lat), 64'd17);
    check_eq("t4_pt", wPlainText, P1);
    check_eq("t4_perr", 64'(wParityErr), 64'd0);

    // Reset in the middle of a decryption.
    start(K3, C3, 1'b0);
    for (int n = 1; n <= 7; n++) tick;
    wReset = 1'b1;
    tick;
    wReset = 1'b0;
    check_eq("t5_ready", 64'(wReady), 64'd1);
    check_eq("t5_pt", wPlainText, 64'd0);
    check_eq("t5_done", 64'(wDone), 64'd0);
    check_eq("t5_perr", 64'(wParityErr), 64'd0);
    count_done(30, cnt);
    check_eq("t5_no_done", 64'(cnt), 64'd0);
    start(K2, C2, 1'b0);
    wait_done(lat, r16);
    check_eq("t5_latency", 64'(lat), 64'd17);
    check_eq("t5_pt_fresh", wPlainText, P2);

    // Reset and start together: reset wins.
    wKey        = K3;
    wCipherText = C1;
    wReset      = 1'b1;
    wStart      = 1'b1;
    tick;
    wReset = 1'b0;
    wStart = 1'b0;
    check_eq("t6_ready", 64'(wReady), 64'd1);
    check_eq("t6_perr", 64'(wParityErr), 64'd0);
    check_eq("t6_pt", wPlainText, 64'd0);
    count_done(25, cnt);
    check_eq("t6_no_done", 64'(cnt), 64'd0);
    check_eq("t6_still_idle", 64'(wReady), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
